// File: rtl/alu_issue_ctrl.sv
// alu_issue_ctrl: decodes ALUOp/funct into ALUControl, registers ALU operands, captures Result/Zero_Flag. ALU_CTRL_ERR_EN enables error responses.
// Latency: rsp_valid 2 cycles after accept (1 cycle for an error response); initiation interval 3.
// Backpressure: req_ready only in IDLE; RESP holds every output until rsp_ready.
module alu_issue_ctrl (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [1:0]  req_aluop,
  input  logic [5:0]  req_funct,
  input  logic [31:0] req_a,
  input  logic [31:0] req_b,
  output logic [3:0]  ALUControl,
  output logic [31:0] A,
  output logic [31:0] B,
  input  logic [31:0] Result,
  input  logic        Zero_Flag,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_result,
  output logic        rsp_zero,
  output logic        rsp_err
);

  typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;

  state_t     state;
  state_t     state_nxt;
  logic [3:0] dec_ctrl;
  logic       accept;
  logic       err_take;

  always_comb begin
    dec_ctrl = 4'b0010;
    case (req_aluop)
      2'b00: dec_ctrl = 4'b0010;
      2'b01: dec_ctrl = 4'b0110;
      2'b11: dec_ctrl = 4'b0001;
      default: begin
        case (req_funct)
          6'b100000: dec_ctrl = 4'b0010;
          6'b100010: dec_ctrl = 4'b0110;
          6'b100100: dec_ctrl = 4'b0000;
          6'b100101: dec_ctrl = 4'b0001;
          6'b101010: dec_ctrl = 4'b0111;
          6'b100111: dec_ctrl = 4'b1100;
          default:   dec_ctrl = 4'b0010;
        endcase
      end
    endcase
  end

  assign accept = req_valid && req_ready;

`ifdef ALU_CTRL_ERR_EN
  logic dec_unsup;

  always_comb begin
    dec_unsup = 1'b0;
    if (req_aluop == 2'b10) begin
      dec_unsup = !(req_funct inside {6'b100000, 6'b100010, 6'b100100,
                                      6'b100101, 6'b101010, 6'b100111});
    end
  end

  assign err_take = accept && dec_unsup;

  always_ff @(posedge clk) begin
    if (reset) begin
      rsp_err <= 1'b0;
    end else if (err_take) begin
      rsp_err <= 1'b1;
    end else if (state == EXEC) begin
      rsp_err <= 1'b0;
    end
  end
`else
  assign err_take = 1'b0;
  assign rsp_err  = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: begin
        if (err_take) begin
          state_nxt = RESP;
        end else if (accept) begin
          state_nxt = EXEC;
        end
      end
      EXEC: state_nxt = RESP;
      RESP: begin
        if (rsp_ready) begin
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    req_ready = (state == IDLE);
    rsp_valid = (state == RESP);
  end

  // Error responses leave the ALU inputs untouched so the ALU keeps its last operation.
  always_ff @(posedge clk) begin
    if (reset) begin
      ALUControl <= 4'b0000;
      A          <= '0;
      B          <= '0;
      rsp_result <= '0;
      rsp_zero   <= 1'b0;
    end else begin
      if (accept && !err_take) begin
        ALUControl <= dec_ctrl;
        A          <= req_a;
        B          <= req_b;
      end
      if (err_take) begin
        rsp_result <= '0;
        rsp_zero   <= 1'b0;
      end else if (state == EXEC) begin
        rsp_result <= Result;
        rsp_zero   <= Zero_Flag;
      end
    end
  end

endmodule

// File: tb/tb_alu_issue_ctrl.sv
// Testbench for alu_issue_ctrl: behavioural ALU stand-in plus a spec-level reference model.
module tb_alu_issue_ctrl;

  logic        clk = 1'b0;
  logic        reset;
  logic        req_valid;
  logic        req_ready;
  logic [1:0]  req_aluop;
  logic [5:0]  req_funct;
  logic [31:0] req_a;
  logic [31:0] req_b;
  logic [3:0]  ALUControl;
  logic [31:0] A;
  logic [31:0] B;
  logic [31:0] Result;
  logic        Zero_Flag;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [31:0] rsp_result;
  logic        rsp_zero;
  logic        rsp_err;

  int          checks = 0;
  int          failures = 0;
  int          cyc = 0;
  logic [31:0] glitch = '0;
  logic        glitch_z = 1'b0;
  logic [3:0]  last_ctrl = 4'b0000;
  logic [5:0]  fns [6] = '{6'b100000, 6'b100010, 6'b100100, 6'b100101, 6'b101010, 6'b100111};

`ifdef ALU_CTRL_ERR_EN
  localparam bit ERR_EN = 1'b1;
`else
  localparam bit ERR_EN = 1'b0;
`endif

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  alu_issue_ctrl dut (
    .clk(clk), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_aluop(req_aluop), .req_funct(req_funct), .req_a(req_a), .req_b(req_b),
    .ALUControl(ALUControl), .A(A), .B(B),
    .Result(Result), .Zero_Flag(Zero_Flag),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_result(rsp_result), .rsp_zero(rsp_zero), .rsp_err(rsp_err)
  );

  // Stand-in combinational ALU; glitch corrupts its outputs outside the sampling edge.
  function automatic logic [31:0] alu_fn(input logic [3:0] c, input logic [31:0] a, input logic [31:0] b);
    case (c)
      4'b0000: return a & b;
      4'b0001: return a | b;
      4'b0010: return a + b;
      4'b0110: return a - b;
      4'b0111: return {31'b0, $signed(a) < $signed(b)};
      4'b1100: return ~(a | b);
      default: return 32'hDEAD_BEEF;
    endcase
  endfunction

  always_comb begin
    Result    = alu_fn(ALUControl, A, B) ^ glitch;
    Zero_Flag = (alu_fn(ALUControl, A, B) == 32'b0) ^ glitch_z;
  end

  function automatic logic model_unsup(input logic [1:0] op, input logic [5:0] fn);
    return (op == 2'b10) && !(fn inside {6'b100000, 6'b100010, 6'b100100, 6'b100101, 6'b101010, 6'b100111});
  endfunction

  function automatic logic [3:0] model_ctrl(input logic [1:0] op, input logic [5:0] fn);
    if (op == 2'b00) return 4'b0010;
    if (op == 2'b01) return 4'b0110;
    if (op == 2'b11) return 4'b0001;
    if (fn == 6'b100010) return 4'b0110;
    if (fn == 6'b100100) return 4'b0000;
    if (fn == 6'b100101) return 4'b0001;
    if (fn == 6'b101010) return 4'b0111;
    if (fn == 6'b100111) return 4'b1100;
    return 4'b0010;
  endfunction

  function automatic logic [31:0] model_res(input logic [1:0] op, input logic [5:0] fn, input logic [31:0] a, input logic [31:0] b);
    if (op == 2'b00) return a + b;
    if (op == 2'b01) return a - b;
    if (op == 2'b11) return a | b;
    if (fn == 6'b100010) return a - b;
    if (fn == 6'b100100) return a & b;
    if (fn == 6'b100101) return a | b;
    if (fn == 6'b101010) return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
    if (fn == 6'b100111) return ~(a | b);
    return a + b;
  endfunction

  // Issues one request and reports latency plus the response as seen just before the handshake.
  task automatic run_op(input logic [1:0] op, input logic [5:0] fn, input logic [31:0] a, input logic [31:0] b,
                        input int stall, output int lat, output logic [3:0] ctrl, output logic [31:0] res,
                        output logic z, output logic err);
    int g;
    glitch = '0;
    glitch_z = 1'b0;
    @(negedge clk);
    req_aluop = op; req_funct = fn; req_a = a; req_b = b;
    req_valid = 1'b1;
    rsp_ready = (stall == 0);
    g = 0;
    while (!req_ready && g < 20) begin
      @(negedge clk);
      g++;
    end
    @(posedge clk); #1;
    req_valid = 1'b0;
    lat = 1;
    while (!rsp_valid && lat < 20) begin
      @(posedge clk); #1;
      lat++;
    end
    for (int s = 0; s < stall; s++) begin
      glitch = $urandom;
      glitch_z = 1'($urandom_range(0, 1));
      @(posedge clk); #1;
    end
    ctrl = ALUControl; res = rsp_result; z = rsp_zero; err = rsp_err;
    rsp_ready = 1'b1;
    @(posedge clk); #1;
    rsp_ready = 1'b0;
    glitch = '0;
    glitch_z = 1'b0;
  endtask

  task automatic test_reset();
    int saw;
    reset = 1'b1; req_valid = 1'b0; rsp_ready = 1'b0;
    req_aluop = '0; req_funct = '0; req_a = '0; req_b = '0;
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    checks++; if (req_ready !== 1'b1) begin failures++; $display("FAIL reset_req_ready got=%0b exp=1", req_ready); end
    checks++; if (rsp_valid !== 1'b0) begin failures++; $display("FAIL reset_rsp_valid got=%0b exp=0", rsp_valid); end
    checks++; if (ALUControl !== 4'b0000) begin failures++; $display("FAIL reset_aluctrl got=%0h exp=0", ALUControl); end
    checks++; if (A !== 32'b0 || B !== 32'b0) begin failures++; $display("FAIL reset_ab got=%0h/%0h exp=0/0", A, B); end
    checks++; if (rsp_result !== 32'b0 || rsp_zero !== 1'b0 || rsp_err !== 1'b0)
      begin failures++; $display("FAIL reset_rsp got=%0h/%0b/%0b exp=0/0/0", rsp_result, rsp_zero, rsp_err); end
    // Accept a request, then hold reset for two cycles while it is in EXEC.
    @(negedge clk);
    req_aluop = 2'b00; req_a = 32'd5; req_b = 32'd6; req_valid = 1'b1; rsp_ready = 1'b1;
    @(posedge clk); #1;
    req_valid = 1'b0; reset = 1'b1;
    @(posedge clk); #1;
    checks++; if (rsp_valid !== 1'b0 || req_ready !== 1'b1)
      begin failures++; $display("FAIL midexec_hs got=%0b/%0b exp=0/1", rsp_valid, req_ready); end
    checks++; if (ALUControl !== 4'b0000 || A !== 32'b0 || B !== 32'b0)
      begin failures++; $display("FAIL midexec_alu got=%0h/%0h/%0h exp=0/0/0", ALUControl, A, B); end
    checks++; if (rsp_result !== 32'b0) begin failures++; $display("FAIL midexec_result got=%0h exp=0", rsp_result); end
    @(posedge clk); #1;
    reset = 1'b0;
    saw = 0;
    repeat (4) begin
      @(posedge clk); #1;
      if (rsp_valid) saw++;
    end
    checks++; if (saw !== 0) begin failures++; $display("FAIL midexec_no_rsp got=%0d exp=0", saw); end
    rsp_ready = 1'b0;
    last_ctrl = 4'b0000;
  endtask

  task automatic test_rtype_sub();
    int lat; logic [3:0] c; logic [31:0] r; logic z, e;
    run_op(2'b10, 6'b100010, 32'd7, 32'd7, 0, lat, c, r, z, e);
    checks++; if (c !== 4'b0110) begin failures++; $display("FAIL sub_ctrl got=%0h exp=6", c); end
    checks++; if (lat !== 2) begin failures++; $display("FAIL sub_latency got=%0d exp=2", lat); end
    checks++; if (r !== 32'd0 || z !== 1'b1 || e !== 1'b0)
      begin failures++; $display("FAIL sub_rsp got=%0h/%0b/%0b exp=0/1/0", r, z, e); end
    last_ctrl = 4'b0110;
  endtask

  task automatic test_slt_nor();
    int lat; logic [3:0] c; logic [31:0] r; logic z, e;
    run_op(2'b10, 6'b101010, 32'd3, 32'd5, 0, lat, c, r, z, e);
    checks++; if (c !== 4'b0111 || r !== 32'd1 || z !== 1'b0)
      begin failures++; $display("FAIL slt got=%0h/%0h/%0b exp=7/1/0", c, r, z); end
    run_op(2'b10, 6'b100111, 32'd0, 32'd0, 0, lat, c, r, z, e);
    checks++; if (c !== 4'b1100 || r !== 32'hFFFF_FFFF || z !== 1'b0)
      begin failures++; $display("FAIL nor got=%0h/%0h/%0b exp=c/ffffffff/0", c, r, z); end
    last_ctrl = 4'b1100;
  endtask

  task automatic test_backpressure();
    int g;
    @(negedge clk);
    req_aluop = 2'b00; req_funct = 6'b0; req_a = 32'h10; req_b = 32'h4;
    req_valid = 1'b1; rsp_ready = 1'b0;
    @(posedge clk); #1;
    req_valid = 1'b0;
    g = 0;
    while (!rsp_valid && g < 10) begin
      @(posedge clk); #1;
      g++;
    end
    for (int i = 0; i < 5; i++) begin
      glitch = $urandom | 32'h1;
      glitch_z = 1'b1;
      @(posedge clk); #1;
      checks++; if (rsp_valid !== 1'b1 || req_ready !== 1'b0)
        begin failures++; $display("FAIL bp_hs[%0d] got=%0b/%0b exp=1/0", i, rsp_valid, req_ready); end
      checks++; if (rsp_result !== 32'h14 || rsp_zero !== 1'b0)
        begin failures++; $display("FAIL bp_result[%0d] got=%0h/%0b exp=14/0", i, rsp_result, rsp_zero); end
      checks++; if (ALUControl !== 4'b0010 || A !== 32'h10 || B !== 32'h4)
        begin failures++; $display("FAIL bp_alu[%0d] got=%0h/%0h/%0h exp=2/10/4", i, ALUControl, A, B); end
    end
    @(negedge clk);
    rsp_ready = 1'b1;
    @(posedge clk); #1;
    checks++; if (req_ready !== 1'b1 || rsp_valid !== 1'b0)
      begin failures++; $display("FAIL bp_release got=%0b/%0b exp=1/0", req_ready, rsp_valid); end
    rsp_ready = 1'b0; glitch = '0; glitch_z = 1'b0;
    last_ctrl = 4'b0010;
  endtask

  task automatic test_back_to_back();
    logic [1:0]  op [3];
    logic [5:0]  fn [3];
    logic [31:0] a [3];
    logic [31:0] b [3];
    logic [31:0] got [$];
    int acc [3] = '{0, 0, 0};
    int idx, guard;
    bit adv;
    for (int i = 0; i < 3; i++) begin
      op[i] = 2'b10; fn[i] = fns[$urandom_range(0, 5)];
      a[i] = $urandom; b[i] = $urandom;
    end
    @(negedge clk);
    rsp_ready = 1'b1;
    req_aluop = op[0]; req_funct = fn[0]; req_a = a[0]; req_b = b[0]; req_valid = 1'b1;
    idx = 0; guard = 0; adv = 1'b0;
    while ((idx < 3 || got.size() < 3) && guard < 40) begin
      if (adv) begin
        idx++;
        adv = 1'b0;
        if (idx < 3) begin
          req_aluop = op[idx]; req_funct = fn[idx]; req_a = a[idx]; req_b = b[idx];
        end else begin
          req_valid = 1'b0;
        end
      end
      if (rsp_valid) got.push_back(rsp_result);
      if (req_valid && req_ready) begin
        acc[idx] = cyc;
        adv = 1'b1;
      end
      @(negedge clk);
      guard++;
    end
    req_valid = 1'b0; rsp_ready = 1'b0;
    checks++; if (acc[1] - acc[0] !== 3 || acc[2] - acc[1] !== 3)
      begin failures++; $display("FAIL b2b_spacing got=%0d,%0d exp=3,3", acc[1] - acc[0], acc[2] - acc[1]); end
    checks++; if (got.size() !== 3) begin failures++; $display("FAIL b2b_count got=%0d exp=3", got.size()); end
    for (int i = 0; i < 3 && i < got.size(); i++) begin
      checks++; if (got[i] !== model_res(op[i], fn[i], a[i], b[i]))
        begin failures++; $display("FAIL b2b_result[%0d] got=%0h exp=%0h", i, got[i], model_res(op[i], fn[i], a[i], b[i])); end
    end
    last_ctrl = model_ctrl(op[2], fn[2]);
  endtask

  task automatic test_unsupported();
    int lat; logic [3:0] c; logic [31:0] r, a, b; logic z, e;
    a = $urandom; b = $urandom;
    run_op(2'b10, 6'b000000, a, b, 0, lat, c, r, z, e);
    if (ERR_EN) begin
      checks++; if (lat !== 1) begin failures++; $display("FAIL unsup_latency got=%0d exp=1", lat); end
      checks++; if (e !== 1'b1 || r !== 32'b0 || z !== 1'b0)
        begin failures++; $display("FAIL unsup_rsp got=%0b/%0h/%0b exp=1/0/0", e, r, z); end
      checks++; if (c !== last_ctrl) begin failures++; $display("FAIL unsup_ctrl got=%0h exp=%0h", c, last_ctrl); end
    end else begin
      checks++; if (lat !== 2) begin failures++; $display("FAIL unsup_latency got=%0d exp=2", lat); end
      checks++; if (e !== 1'b0 || r !== a + b || z !== (a + b == 32'b0))
        begin failures++; $display("FAIL unsup_rsp got=%0b/%0h/%0b exp=0/%0h/%0b", e, r, z, a + b, a + b == 32'b0); end
      checks++; if (c !== 4'b0010) begin failures++; $display("FAIL unsup_ctrl got=%0h exp=2", c); end
      last_ctrl = 4'b0010;
    end
  endtask

  task automatic test_random();
    int lat, stall; logic [3:0] c; logic [31:0] r, a, b; logic z, e;
    logic [1:0] op; logic [5:0] fn;
    logic is_err; logic [3:0] x_ctrl; logic [31:0] x_res;
    for (int i = 0; i < 30; i++) begin
      op = 2'($urandom_range(0, 3));
      fn = ($urandom_range(0, 3) == 0) ? 6'($urandom) : fns[$urandom_range(0, 5)];
      a = $urandom;
      b = ($urandom_range(0, 3) == 0) ? a : $urandom;
      stall = $urandom_range(0, 3);
      is_err = ERR_EN && model_unsup(op, fn);
      x_ctrl = is_err ? last_ctrl : model_ctrl(op, fn);
      x_res = is_err ? 32'b0 : model_res(op, fn, a, b);
      run_op(op, fn, a, b, stall, lat, c, r, z, e);
      checks++; if (lat !== (is_err ? 1 : 2)) begin failures++; $display("FAIL rnd_latency[%0d] got=%0d exp=%0d", i, lat, is_err ? 1 : 2); end
      checks++; if (c !== x_ctrl) begin failures++; $display("FAIL rnd_ctrl[%0d] got=%0h exp=%0h", i, c, x_ctrl); end
      checks++; if (r !== x_res) begin failures++; $display("FAIL rnd_result[%0d] got=%0h exp=%0h", i, r, x_res); end
      checks++; if (z !== (!is_err && x_res == 32'b0)) begin failures++; $display("FAIL rnd_zero[%0d] got=%0b exp=%0b", i, z, !is_err && x_res == 32'b0); end
      checks++; if (e !== is_err) begin failures++; $display("FAIL rnd_err[%0d] got=%0b exp=%0b", i, e, is_err); end
      last_ctrl = x_ctrl;
    end
  endtask

  initial begin
    test_reset();
    test_rtype_sub();
    test_slt_nor();
    test_backpressure();
    test_back_to_back();
    test_unsupported();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
